// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-allocate, write-back data cache controller.
// Owns tag/valid/dirty state and drives the data SRAM and the DRAM block handshake.
module dcache_controller #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int INDEX_W     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cpu_req_valid,
    input  logic                          cpu_req_rw,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [WORD_W-1:0]             cpu_wdata,
    output logic                          cpu_ready,
    output logic [WORD_W-1:0]             cpu_rdata,
    output logic                          mem_req_valid,
    output logic                          mem_req_rw,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [WORD_W*BLOCK_WORDS-1:0] mem_wdata,
    input  logic                          mem_ready,
    input  logic [WORD_W*BLOCK_WORDS-1:0] mem_rdata,
    output logic                          sram_we,
    output logic [INDEX_W-1:0]            sram_index,
    output logic [WORD_W*BLOCK_WORDS-1:0] sram_data_write,
    input  logic [WORD_W*BLOCK_WORDS-1:0] sram_data_read,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int LO_W  = OFF_W + 2;
    localparam int TAG_W = ADDR_W - INDEX_W - LO_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-3:0]       addr_q, addr_d;
    logic                    rw_q, rw_d;
    logic [WORD_W-1:0]       wdata_q, wdata_d;
    logic                    refill_q, refill_d;
    logic [31:0]             hit_q, hit_d, miss_q, miss_d;
    logic [LINES-1:0]        valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q [LINES];
    logic                    tag_we;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      idx;
    logic [OFF_W-1:0]        off;
    logic                    hit;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] rd_words, wr_words;
    logic                    unused_byte_bits;

    assign unused_byte_bits = ^cpu_addr[1:0];
    assign req_tag    = addr_q[ADDR_W-3 -: TAG_W];
    assign idx        = addr_q[OFF_W +: INDEX_W];
    assign off        = addr_q[0 +: OFF_W];
    assign hit        = valid_q[idx] && (tag_q[idx] == req_tag);
    assign rd_words   = sram_data_read;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            refill_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            refill_q <= refill_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
        end
    end

    // Tags need no reset: valid gates every use.
    always_ff @(posedge clock) begin
        if (tag_we) tag_q[idx] <= req_tag;
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rw_d            = rw_q;
        wdata_d         = wdata_q;
        refill_d        = refill_q;
        hit_d           = hit_q;
        miss_d          = miss_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_we          = 1'b0;
        wr_words        = rd_words;
        cpu_ready       = 1'b0;
        cpu_rdata       = '0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        sram_we         = 1'b0;
        sram_index      = (state_q == IDLE) ? cpu_addr[LO_W +: INDEX_W] : idx;
        sram_data_write = '0;
        case (state_q)
            IDLE: begin
                refill_d = 1'b0;
                if (cpu_req_valid) begin
                    addr_d  = cpu_addr[ADDR_W-1:2];
                    rw_d    = cpu_req_rw;
                    wdata_d = cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                    refill_d  = 1'b0;
                    hit_d     = refill_q ? hit_q : hit_q + 32'd1;
                    if (rw_q) begin
                        wr_words[off]   = wdata_q;
                        sram_we         = 1'b1;
                        sram_data_write = wr_words;
                        dirty_d[idx]    = 1'b1;
                    end else begin
                        cpu_rdata = rd_words[off];
                    end
                end else begin
                    miss_d  = miss_q + 32'd1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_addr      = {tag_q[idx], idx, {LO_W{1'b0}}};
                mem_wdata     = sram_data_read;
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_addr      = {req_tag, idx, {LO_W{1'b0}}};
                if (mem_ready) begin
                    sram_we         = 1'b1;
                    sram_data_write = mem_rdata;
                    tag_we          = 1'b1;
                    valid_d[idx]    = 1'b1;
                    dirty_d[idx]    = 1'b0;
                    refill_d        = 1'b1;
                    state_d         = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scenarios checked against a residency/memory model of the cache,
// with a DRAM responder and a combinational data SRAM model around the controller.
module tb_dcache_controller;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         mem_req_valid, mem_req_rw;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         sram_we;
    logic [3:0]   sram_index;
    logic [127:0] sram_data_write, sram_data_read;
    logic [31:0]  hit_count, miss_count;

    always #5 clock = ~clock;

    dcache_controller dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .sram_we(sram_we), .sram_index(sram_index), .sram_data_write(sram_data_write),
        .sram_data_read(sram_data_read), .hit_count(hit_count), .miss_count(miss_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [127:0] sram [16];
    assign sram_data_read = sram[sram_index];
    always @(posedge clock) if (sram_we) sram[sram_index] <= sram_data_write;

    logic [31:0] dram [int];
    logic [31:0] gold [int];

    function automatic logic [31:0] dram_word(input logic [31:0] a);
        return dram.exists(int'(a)) ? dram[int'(a)] : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : dram_word(a);
    endfunction

    int mem_delay = 0;
    int wait_cnt = 0;
    always @(negedge clock) begin
        mem_ready = 1'b0;
        if (mem_req_valid && !reset) begin
            if (wait_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                wait_cnt = 0;
                for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = dram_word(mem_addr + 32'(4*i));
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    // Model state: which block each line holds, whether it is dirty, and counter expectations.
    logic         res_valid [16];
    logic         res_dirty [16];
    logic [31:0]  res_blk [16];
    int           exp_hits = 0, exp_misses = 0;
    logic         busy = 1'b0, cur_rw = 1'b0, exp_hit = 1'b0, exp_wb = 1'b0;
    logic [31:0]  cur_blk = '0, exp_rdata = '0, exp_wb_addr = '0;
    logic [127:0] exp_wb_data = '0;

    int           we_pulses = 0;
    logic [127:0] last_we_data = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;
    logic         prev_v = 1'b0, prev_rw = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [127:0] prev_wdata = '0;

    always @(posedge clock) begin
        #1;
        if (cpu_ready) begin
            chk("ready_outstanding", busy, 1);
            chk("cpu_rdata", cpu_rdata, cur_rw ? 32'h0 : exp_rdata);
        end else chk("rdata_quiet", cpu_rdata, 0);
        if (!busy) chk("sram_index_idle", sram_index, cpu_addr[7:4]);
        if (sram_we) begin
            chk("we_outstanding", busy, 1);
            chk("sram_index_we", sram_index, cur_blk[7:4]);
            we_pulses++;
            last_we_data = sram_data_write;
        end
        if (mem_req_valid) begin
            chk("mem_only_on_miss", busy && !exp_hit, 1);
            if (mem_req_rw) begin
                chk("wb_expected", exp_wb, 1);
                chk("wb_addr", mem_addr, exp_wb_addr);
                chk("wb_data", mem_wdata, exp_wb_data);
                last_wb_addr = mem_addr;
                last_wb_data = mem_wdata;
            end else chk("refill_addr", mem_addr, cur_blk);
            if (prev_v && !mem_ready) begin
                chk("stable_rw", mem_req_rw, prev_rw);
                chk("stable_addr", mem_addr, prev_addr);
                chk("stable_wdata", mem_wdata, prev_wdata);
            end
        end
        prev_v = mem_req_valid;
        prev_rw = mem_req_rw;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_blk[i] = '0;
        end
        exp_hits = 0;
        exp_misses = 0;
        gold.delete();
    endtask

    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int idx, exp_lat;
        logic [31:0] blk;
        logic done;
        @(posedge clock); #2;
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
        idx = int'(a[7:4]);
        blk = {a[31:4], 4'h0};
        exp_hit = res_valid[idx] && res_blk[idx] == blk;
        exp_wb = !exp_hit && res_valid[idx] && res_dirty[idx];
        exp_wb_addr = res_blk[idx];
        for (int i = 0; i < 4; i++) exp_wb_data[32*i +: 32] = exp_word(res_blk[idx] + 32'(4*i));
        if (exp_wb)
            for (int i = 0; i < 4; i++) dram[int'(res_blk[idx] + 32'(4*i))] = exp_word(res_blk[idx] + 32'(4*i));
        exp_rdata = exp_word({a[31:2], 2'b00});
        cur_rw = rw;
        cur_blk = blk;
        exp_lat = exp_hit ? 1 : (exp_wb ? 2 + 2 * (mem_delay + 1) : 3 + mem_delay);
        busy = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_rw = rw;
        cpu_addr = a;
        cpu_wdata = wd;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(posedge clock); #2;
            lat++;
            done = cpu_ready;
        end
        rd = cpu_rdata;
        cpu_req_valid = 1'b0;
        cpu_req_rw = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        busy = 1'b0;
        chk("completed", done, 1);
        chk("latency", lat, exp_lat);
        if (exp_hit) exp_hits++; else exp_misses++;
        res_dirty[idx] = (exp_hit && res_dirty[idx]) || rw;
        res_valid[idx] = 1'b1;
        res_blk[idx] = blk;
        if (rw) gold[int'({a[31:2], 2'b00})] = wd;
    endtask

    initial begin
        logic [31:0] rd;
        int lat, we_base, n;
        for (int i = 0; i < 16; i++) sram[i] = '0;
        model_reset();
        dram[32'h10] = 32'h11;
        dram[32'h14] = 32'h22;
        dram[32'h18] = 32'h33;
        dram[32'h1C] = 32'h44;
        #2 reset = 1'b1;
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_rw", mem_req_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_index", sram_index, 0);
        chk("rst_sram_wdata", sram_data_write, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        access(1'b0, 32'h10, 32'h0, rd, lat);
        chk("t1_rdata", rd, 32'h11);
        chk("t1_latency", lat, 3);
        chk("t1_miss", miss_count, 1);
        chk("t1_hit", hit_count, 0);

        access(1'b0, 32'h18, 32'h0, rd, lat);
        chk("t2_rdata", rd, 32'h33);
        chk("t2_latency", lat, 1);
        @(posedge clock); #2;
        chk("t2_hit", hit_count, 1);

        we_base = we_pulses;
        access(1'b1, 32'h14, 32'hDEADBEEF, rd, lat);
        chk("t3_latency", lat, 1);
        chk("t3_we_pulses", we_pulses - we_base, 1);
        chk("t3_we_block", last_we_data, 128'h00000044_00000033_DEADBEEF_00000011);
        access(1'b0, 32'h14, 32'h0, rd, lat);
        chk("t3_readback", rd, 32'hDEADBEEF);

        access(1'b0, 32'h110, 32'h0, rd, lat);
        chk("t4_latency", lat, 4);
        chk("t4_rdata", rd, 32'hA5A50110);
        chk("t4_wb_addr", last_wb_addr, 32'h10);
        chk("t4_wb_data", last_wb_data, 128'h00000044_00000033_DEADBEEF_00000011);
        chk("t4_miss", miss_count, 2);

        mem_delay = 5;
        access(1'b0, 32'h220, 32'h0, rd, lat);
        chk("t5_latency", lat, 8);
        chk("t5_rdata", rd, 32'hA5A50220);
        mem_delay = 0;

        access(1'b1, 32'h32C, 32'h12345678, rd, lat);
        chk("wmiss_latency", lat, 3);
        access(1'b0, 32'h32C, 32'h0, rd, lat);
        chk("wmiss_readback", rd, 32'h12345678);
        access(1'b0, 32'h1320, 32'h0, rd, lat);
        chk("dirty_evict_latency", lat, 4);
        chk("dirty_evict_addr", last_wb_addr, 32'h320);
        access(1'b0, 32'h32C, 32'h0, rd, lat);
        chk("refetch_written", rd, 32'h12345678);
        access(1'b0, 32'h32F, 32'h0, rd, lat);
        chk("byte_bits_ignored", rd, 32'h12345678);
        chk("byte_bits_hit_latency", lat, 1);

        @(posedge clock); #2;
        exp_hit = 1'b0;
        exp_wb = 1'b0;
        cur_rw = 1'b0;
        cur_blk = 32'h210;
        busy = 1'b1;
        mem_delay = 100;
        cpu_req_valid = 1'b1;
        cpu_addr = 32'h210;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(posedge clock); #2;
            n++;
        end
        chk("t6_alloc_seen", mem_req_valid && !mem_req_rw, 1);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_mem_drop", mem_req_valid, 0);
        chk("t6_no_ready", cpu_ready, 0);
        chk("t6_hits_clr", hit_count, 0);
        chk("t6_misses_clr", miss_count, 0);
        busy = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_addr = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        mem_delay = 0;
        repeat (4) @(posedge clock);

        access(1'b0, 32'h110, 32'h0, rd, lat);
        chk("t6_after_latency", lat, 3);
        chk("t6_after_rdata", rd, 32'hA5A50110);
        chk("t6_after_miss", miss_count, 1);
        chk("t6_after_hit", hit_count, 0);
        access(1'b0, 32'h114, 32'h0, rd, lat);
        chk("t6_hit_rdata", rd, 32'hA5A50114);
        @(posedge clock); #2;
        chk("t6_hit_count", hit_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end
endmodule
